collision_scheduler: RTL and testbench
======================================

# collision_scheduler

Time-multiplexed collision checker for the runner game. Once per frame `update`, the runner pulses `start`. The block then walks every active obstacle through one shared axis-aligned-box overlap comparator and reports `crashed` before the next frame. The result replaces the runner's constant `crashed = 0` stub and drives its RUNNING→CRASHED transition. Checking is two-level: a coarse outer-box test first, then a fine per-sub-box test, the same rule as the game's reference physics.

## Interface
- `MAX_OBSTACLES`, default 3: obstacle slots scanned, index 0 first.
- `TREX_BOXES`, default 6: standing T-rex sub-boxes, using the runner's T-rex collision table.
- Reset `rst`, synchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a check; sampled only in IDLE.
- `ducking`  in  1  use the single duck box instead of the 6 standing boxes.
- `trex_x`, `trex_y`  in  10 each  T-rex origin, game pixels.
- `trex_w`, `trex_h`  in  10 each  T-rex extent.
- `obstacle_valid[MAX_OBSTACLES]`  in  1 each  slot active.
- `obstacle_x[]`  in  11 signed  slot x.
- `obstacle_y[]`  in  10  slot y.
- `obstacle_w[]`  in  10  total width, i.e. unit width × size.
- `obstacle_h[]`  in  10  height.
- `obstacle_kind[]`  in  2  0 = cactus small, 1 = cactus large, 2 = pterodactyl.
- `obstacle_size[]`  in  2  group size 1–3.
- `busy`  out  1  high from the cycle after start is accepted until DONE.
- `done`  out  1  one-cycle pulse, asserted in DONE.
- `crashed`  out  1  result of the last check; held until the next accepted start.
- `hit_index`  out  2  slot that caused the hit; valid when `crashed`.

## Operation
- **FSM states:** IDLE, OUTER, FINE, DONE.
- **IDLE:**
  - On `start`, snapshot all inputs, clear `crashed` and set obstacle index `oi = 0`, then go to OUTER.
  - `start` outside IDLE is ignored.
- **OUTER** (one obstacle per cycle):
  - Build the T-rex outer box as (x+1, y+1, w−2, h−2) and the obstacle outer box the same way.
  - If the slot is invalid or there is no overlap: if `oi == MAX_OBSTACLES−1`, go to DONE; otherwise increment `oi`.
  - If the boxes overlap: set sub-box counters `tb = 0`, `ob = 0` and go to FINE.
- **FINE** (one sub-box pair per cycle):
  - T-rex box count is 1 if `ducking`, else `TREX_BOXES`. Obstacle box count is 3 for cacti and 5 for the pterodactyl.
  - Pair order: `ob` varies fastest, then `tb`.
  - On a hit: set `crashed = 1`, set `hit_index = oi`, go to DONE.
  - After the last pair: advance to the next obstacle in OUTER, or go to DONE if `oi` was the last slot.
- **Sub-box rule:** sub-box offsets are relative to the element origin.
- **Cactus group adjustment** (`size > 1`):
  - box1.w = total_w − box0.w − box2.w.
  - box2.x = total_w − box2.w.
- **Overlap test:** `a.x < b.x+b.w && a.x+a.w > b.x && a.y < b.y+b.h && a.y+a.h > b.y`. Edges that only touch do not overlap.
- **Arithmetic width:** all sums are 12-bit signed. Negative obstacle x, i.e. an obstacle partly off the left edge, is handled correctly.
- **DONE:** assert `done` for one cycle, drop `busy` in the same cycle, return to IDLE.

## Timing
- Start is sampled at cycle 0 and OUTER begins at cycle 1.
- **Latency to `done`:** 1 + Σ per slot (1 + fine pairs evaluated) cycles.
- **Worst case**, 3 slots, standing, all pterodactyl, no hit: 1 + 3×(1+30) = 94 cycles, which fits within one frame.
- **Reset values:**
  - State IDLE.
  - `busy`, `done`, `crashed` = 0.
  - `hit_index` = 0.
  - All counters = 0.
- **Reset mid-check:** aborts immediately. The next cycle is IDLE with reset outputs, and no `done` is issued.
- **`start` in the DONE cycle:** ignored; a new start is accepted only in IDLE.
- **Input changes while busy:** no effect, because the check runs on the snapshot.
- **Output update timing:** `crashed` and `hit_index` change only in the cycle FINE detects a hit, or when an accepted start clears `crashed`.

## Test plan
- **All slots invalid:** `start` at cycle 0 → `done` at cycle 4; `crashed = 0`; `busy` high during cycles 1–3.
- **Direct hit:**
  - Stimulus: T-rex at (50,93), 44×47, standing; slot 0 is a small cactus at (60,105), 17×35, size 1; slots 1–2 invalid.
  - Response: pairs (0,0), (0,1), (0,2), (1,0) are evaluated; hit at cycle 5; `done` at cycle 6; `crashed = 1`; `hit_index = 0`.
- **Near miss:**
  - Stimulus: same T-rex; slot 0 cactus at x = 90, y = 93.
  - Response: outer boxes overlap but all 18 fine pairs miss; `done` at cycle 22; `crashed = 0`.
- **Ducking:** T-rex ducking with a pterodactyl in slot 2, overlapping outer boxes and no hit → 1 duck box × 5 pterodactyl boxes = 5 fine cycles; `done` at cycle 9.
- **Size-3 large cactus:** place the T-rex so it intersects only the stretched middle box → hit detected, `crashed = 1`.
- **Control robustness:**
  - Re-pulse `start` at cycle 2 → ignored.
  - Assert `rst` at cycle 3 → no `done`; all outputs 0 at cycle 4.
  - A fresh start after a hit clears `crashed` at cycle 1.

Source files
------------

// File: rtl/collision_scheduler_if.sv
// Handshake and geometry bundle between the runner and the collision scheduler.
interface collision_scheduler_if #(
  parameter int MAX_OBSTACLES = 3
);
  logic              start;
  logic              ducking;
  logic [9:0]        trex_x;
  logic [9:0]        trex_y;
  logic [9:0]        trex_w;
  logic [9:0]        trex_h;
  logic              obstacle_valid [MAX_OBSTACLES];
  logic signed [10:0] obstacle_x    [MAX_OBSTACLES];
  logic [9:0]        obstacle_y     [MAX_OBSTACLES];
  logic [9:0]        obstacle_w     [MAX_OBSTACLES];
  logic [9:0]        obstacle_h     [MAX_OBSTACLES];
  logic [1:0]        obstacle_kind  [MAX_OBSTACLES];
  logic [1:0]        obstacle_size  [MAX_OBSTACLES];
  logic              busy;
  logic              done;
  logic              crashed;
  logic [1:0]        hit_index;

  modport master (
    output start, ducking, trex_x, trex_y, trex_w, trex_h,
           obstacle_valid, obstacle_x, obstacle_y, obstacle_w, obstacle_h,
           obstacle_kind, obstacle_size,
    input  busy, done, crashed, hit_index
  );

  modport slave (
    input  start, ducking, trex_x, trex_y, trex_w, trex_h,
           obstacle_valid, obstacle_x, obstacle_y, obstacle_w, obstacle_h,
           obstacle_kind, obstacle_size,
    output busy, done, crashed, hit_index
  );
endinterface

// File: rtl/collision_scheduler.sv
// Frame-rate collision checker: walks obstacle slots through one shared box
// comparator, coarse outer box first, then every T-rex/obstacle sub-box pair.
module collision_scheduler #(
  parameter int MAX_OBSTACLES = 3,
  parameter int TREX_BOXES    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  collision_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OUTER = 2'd1;
  localparam logic [1:0] FINE  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } box_t;

  function automatic box_t mk(input int x, input int y, input int w, input int h);
    return '{x: 12'(x), y: 12'(y), w: 12'(w), h: 12'(h)};
  endfunction

  function automatic box_t place(input box_t b, input logic [11:0] ox, input logic [11:0] oy);
    box_t r;
    r   = b;
    r.x = b.x + ox;
    r.y = b.y + oy;
    return r;
  endfunction

  // Signed compare lets obstacles hanging off the left edge behave correctly.
  function automatic logic overlap(input box_t a, input box_t b);
    logic signed [11:0] ax, ay, aw, ah, bx, by, bw, bh;
    {ax, ay, aw, ah} = a;
    {bx, by, bw, bh} = b;
    return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
  endfunction

  function automatic box_t trex_box(input logic duck, input logic [2:0] i);
    if (duck) return mk(1, 18, 55, 25);
    case (i)
      3'd0:    return mk(22, 0, 17, 16);
      3'd1:    return mk(1, 18, 30, 9);
      3'd2:    return mk(10, 35, 14, 8);
      3'd3:    return mk(1, 24, 29, 5);
      3'd4:    return mk(5, 30, 21, 4);
      default: return mk(9, 34, 15, 4);
    endcase
  endfunction

  function automatic box_t obs_box(input logic [1:0] kind, input logic [1:0] size,
                                   input logic [11:0] total_w, input logic [2:0] j);
    box_t c0, c1, c2;
    if (kind == 2'd2) begin
      case (j)
        3'd0:    return mk(15, 15, 16, 5);
        3'd1:    return mk(18, 21, 24, 6);
        3'd2:    return mk(2, 14, 4, 3);
        3'd3:    return mk(6, 10, 4, 7);
        default: return mk(10, 8, 6, 9);
      endcase
    end
    if (kind == 2'd1) begin
      c0 = mk(0, 12, 7, 38);
      c1 = mk(8, 0, 7, 49);
      c2 = mk(13, 10, 10, 38);
    end else begin
      c0 = mk(0, 7, 5, 27);
      c1 = mk(4, 0, 6, 34);
      c2 = mk(10, 4, 7, 14);
    end
    // Groups stretch the middle box and pin the last box to the right edge.
    if (size > 2'd1) begin
      c1.w = total_w - c0.w - c2.w;
      c2.x = total_w - c2.w;
    end
    case (j)
      3'd0:    return c0;
      3'd1:    return c1;
      default: return c2;
    endcase
  endfunction

  logic [1:0]  state;
  logic [1:0]  oi;
  logic [2:0]  tb, ob;
  logic        busy_q, done_q, crashed_q;
  logic [1:0]  hit_q;

  logic        s_duck;
  logic [11:0] s_tx, s_ty, s_tw, s_th;
  logic        s_valid [MAX_OBSTACLES];
  logic [11:0] s_ox    [MAX_OBSTACLES];
  logic [11:0] s_oy    [MAX_OBSTACLES];
  logic [11:0] s_ow    [MAX_OBSTACLES];
  logic [11:0] s_oh    [MAX_OBSTACLES];
  logic [1:0]  s_kind  [MAX_OBSTACLES];
  logic [1:0]  s_size  [MAX_OBSTACLES];

  box_t t_outer, o_outer, t_fine, o_fine;
  logic outer_hit, fine_hit, ob_last, tb_last, slot_last;

  always_comb begin
    t_outer   = '{x: s_tx + 12'd1, y: s_ty + 12'd1, w: s_tw - 12'd2, h: s_th - 12'd2};
    o_outer   = '{x: s_ox[oi] + 12'd1, y: s_oy[oi] + 12'd1,
                  w: s_ow[oi] - 12'd2, h: s_oh[oi] - 12'd2};
    outer_hit = s_valid[oi] && overlap(t_outer, o_outer);
    t_fine    = place(trex_box(s_duck, tb), s_tx, s_ty);
    o_fine    = place(obs_box(s_kind[oi], s_size[oi], s_ow[oi], ob), s_ox[oi], s_oy[oi]);
    fine_hit  = overlap(t_fine, o_fine);
    ob_last   = (ob == ((s_kind[oi] == 2'd2) ? 3'd4 : 3'd2));
    tb_last   = s_duck || (tb == 3'(TREX_BOXES - 1));
    slot_last = (oi == 2'(MAX_OBSTACLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.start) begin
      s_duck <= bus.ducking;
      s_tx   <= {2'b00, bus.trex_x};
      s_ty   <= {2'b00, bus.trex_y};
      s_tw   <= {2'b00, bus.trex_w};
      s_th   <= {2'b00, bus.trex_h};
      for (int unsigned i = 0; i < MAX_OBSTACLES; i++) begin
        s_valid[i] <= bus.obstacle_valid[i];
        s_ox[i]    <= {bus.obstacle_x[i][10], bus.obstacle_x[i]};
        s_oy[i]    <= {2'b00, bus.obstacle_y[i]};
        s_ow[i]    <= {2'b00, bus.obstacle_w[i]};
        s_oh[i]    <= {2'b00, bus.obstacle_h[i]};
        s_kind[i]  <= bus.obstacle_kind[i];
        s_size[i]  <= bus.obstacle_size[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      oi        <= '0;
      tb        <= '0;
      ob        <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crashed_q <= 1'b0;
      hit_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            crashed_q <= 1'b0;
            oi        <= '0;
            busy_q    <= 1'b1;
            state     <= OUTER;
          end
        end
        OUTER: begin
          if (outer_hit) begin
            tb    <= '0;
            ob    <= '0;
            state <= FINE;
          end else if (slot_last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            oi <= oi + 2'd1;
          end
        end
        FINE: begin
          if (fine_hit) begin
            crashed_q <= 1'b1;
            hit_q     <= oi;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else if (!ob_last) begin
            ob <= ob + 3'd1;
          end else if (!tb_last) begin
            ob <= '0;
            tb <= tb + 3'd1;
          end else if (slot_last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            oi    <= oi + 2'd1;
            state <= OUTER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.crashed   = crashed_q;
  assign bus.hit_index = hit_q;
endmodule

// File: tb/tb_collision_scheduler.sv
// Randomised bench for collision_scheduler against a brute-force box model.
module tb_collision_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_scheduler_if #(.MAX_OBSTACLES(3)) bus ();
  collision_scheduler #(.MAX_OBSTACLES(3), .TREX_BOXES(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  typedef struct packed { int lat; bit hit; int idx; } res_t;

  int trex_t [6][4] = '{'{22, 0, 17, 16}, '{1, 18, 30, 9}, '{10, 35, 14, 8},
                        '{1, 24, 29, 5}, '{5, 30, 21, 4}, '{9, 34, 15, 4}};
  int duck_t [4]    = '{1, 18, 55, 25};
  int small_t[3][4] = '{'{0, 7, 5, 27}, '{4, 0, 6, 34}, '{10, 4, 7, 14}};
  int large_t[3][4] = '{'{0, 12, 7, 38}, '{8, 0, 7, 49}, '{13, 10, 10, 38}};
  int ptero_t[5][4] = '{'{15, 15, 16, 5}, '{18, 21, 24, 6}, '{2, 14, 4, 3},
                        '{6, 10, 4, 7}, '{10, 8, 6, 9}};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ovl(input int ax, input int ay, input int aw, input int ah,
                             input int bx, input int by, input int bw, input int bh);
    return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
  endfunction

  // Whole-check outcome from the current inputs: done cycle, hit flag, slot.
  function automatic res_t evaluate();
    res_t r;
    int tx, ty, tw, th, ox, oy, ow, oh, kind, size, nb, nt;
    int ob[5][4];
    int tbx[4];
    r.lat = 1; r.hit = 1'b0; r.idx = 0;
    tx = bus.trex_x; ty = bus.trex_y; tw = bus.trex_w; th = bus.trex_h;
    nt = bus.ducking ? 1 : 6;
    for (int s = 0; s < 3; s++) begin
      r.lat++;
      if (!bus.obstacle_valid[s]) continue;
      ox = bus.obstacle_x[s]; oy = bus.obstacle_y[s];
      ow = bus.obstacle_w[s]; oh = bus.obstacle_h[s];
      kind = bus.obstacle_kind[s]; size = bus.obstacle_size[s];
      if (!ovl(tx + 1, ty + 1, tw - 2, th - 2, ox + 1, oy + 1, ow - 2, oh - 2)) continue;
      nb = (kind == 2) ? 5 : 3;
      for (int j = 0; j < nb; j++)
        for (int k = 0; k < 4; k++)
          ob[j][k] = (kind == 2) ? ptero_t[j][k] : (kind == 1) ? large_t[j][k] : small_t[j][k];
      if (kind != 2 && size > 1) begin
        ob[1][2] = ow - ob[0][2] - ob[2][2];
        ob[2][0] = ow - ob[2][2];
      end
      for (int t = 0; t < nt; t++) begin
        for (int k = 0; k < 4; k++) tbx[k] = bus.ducking ? duck_t[k] : trex_t[t][k];
        for (int j = 0; j < nb; j++) begin
          r.lat++;
          if (ovl(tx + tbx[0], ty + tbx[1], tbx[2], tbx[3],
                  ox + ob[j][0], oy + ob[j][1], ob[j][2], ob[j][3])) begin
            r.hit = 1'b1;
            r.idx = s;
            return r;
          end
        end
      end
    end
    return r;
  endfunction

  res_t       m_res;
  int         m_k = 0;
  bit         m_run = 1'b0;
  logic       e_busy = 1'b0, e_done = 1'b0, e_crashed = 1'b0;
  logic [1:0] e_hidx = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_crashed <= 1'b0; e_hidx <= '0;
    end else if (!m_run) begin
      e_done <= 1'b0;
      if (bus.start) begin
        m_res     <= evaluate();
        m_k       <= 1;
        m_run     <= 1'b1;
        e_busy    <= 1'b1;
        e_crashed <= 1'b0;
      end
    end else if (m_k == m_res.lat) begin
      m_run <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0;
    end else begin
      m_k    <= m_k + 1;
      e_busy <= (m_k + 1 < m_res.lat);
      e_done <= (m_k + 1 == m_res.lat);
      if (m_k + 1 == m_res.lat && m_res.hit) begin
        e_crashed <= 1'b1;
        e_hidx    <= 2'(m_res.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", int'(bus.busy), int'(e_busy));
      chk("done", int'(bus.done), int'(e_done));
      chk("crashed", int'(bus.crashed), int'(e_crashed));
      chk("hit_index", int'(bus.hit_index), int'(e_hidx));
    end
  end

  task automatic set_trex(input int x, input int y, input int w, input int h, input bit duck);
    bus.trex_x = 10'(x); bus.trex_y = 10'(y); bus.trex_w = 10'(w); bus.trex_h = 10'(h);
    bus.ducking = duck;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 3; i++) begin
      bus.obstacle_valid[i] = 1'b0; bus.obstacle_x[i] = '0; bus.obstacle_y[i] = '0;
      bus.obstacle_w[i] = '0; bus.obstacle_h[i] = '0;
      bus.obstacle_kind[i] = '0; bus.obstacle_size[i] = 2'd1;
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int kind, input int size);
    int uw, uh;
    uw = (kind == 2) ? 46 : (kind == 1) ? 25 : 17;
    uh = (kind == 2) ? 40 : (kind == 1) ? 50 : 35;
    bus.obstacle_valid[i] = 1'b1;
    bus.obstacle_x[i]     = 11'(x);
    bus.obstacle_y[i]     = 10'(y);
    bus.obstacle_w[i]     = 10'(uw * size);
    bus.obstacle_h[i]     = 10'(uh);
    bus.obstacle_kind[i]  = 2'(kind);
    bus.obstacle_size[i]  = 2'(size);
  endtask

  task automatic rand_inputs();
    int kind, size;
    set_trex($urandom_range(0, 140), $urandom_range(60, 110), $urandom_range(40, 60),
             $urandom_range(25, 50), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) begin
      kind = $urandom_range(0, 2);
      size = (kind == 2) ? 1 : $urandom_range(1, 3);
      set_slot(i, int'($urandom_range(0, 220)) - 60, $urandom_range(60, 130), kind, size);
      bus.obstacle_valid[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Pulses start, returns the cycle (relative to the accepting edge) done was seen.
  task automatic run(input bit perturb, output int dcyc);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("crashed_clear_c1", int'(bus.crashed), 0);
    dcyc = 0;
    for (int n = 1; n <= 300; n++) begin
      if (bus.done) begin dcyc = n; break; end
      if (perturb) begin
        if ($urandom_range(0, 3) == 0) rand_inputs();
        bus.start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    chk("done_seen", int'(dcyc != 0), 1);
    bus.start = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk); bus.start = 1'b0;
  endtask

  initial begin
    int d, seen;
    res_t r;
    rst = 1'b1; bus.start = 1'b0;
    set_trex(50, 93, 44, 47, 1'b0);
    clear_slots();
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_crashed", int'(bus.crashed), 0);
    chk("reset_hit_index", int'(bus.hit_index), 0);
    rst = 1'b0;

    run(1'b0, d);
    chk("invalid_done_cycle", d, 4);
    chk("invalid_crashed", int'(bus.crashed), 0);

    set_slot(0, 60, 105, 0, 1);
    r = evaluate();
    chk("model_direct_lat", r.lat, 6);
    chk("model_direct_hit", int'(r.hit), 1);
    run(1'b0, d);
    chk("direct_done_cycle", d, 6);
    chk("direct_crashed", int'(bus.crashed), 1);
    chk("direct_hit_index", int'(bus.hit_index), 0);

    set_slot(0, 90, 93, 0, 1);
    run(1'b0, d);
    chk("near_done_cycle", d, 22);
    chk("near_crashed", int'(bus.crashed), 0);

    set_trex(50, 100, 59, 47, 1'b1);
    clear_slots();
    set_slot(2, 60, 91, 2, 1);
    run(1'b0, d);
    chk("duck_done_cycle", d, 9);
    chk("duck_crashed", int'(bus.crashed), 0);

    set_trex(124, 70, 59, 47, 1'b1);
    clear_slots();
    set_slot(1, 100, 110, 1, 3);
    run(1'b0, d);
    chk("size3_done_cycle", d, 5);
    chk("size3_crashed", int'(bus.crashed), 1);
    chk("size3_hit_index", int'(bus.hit_index), 1);

    set_trex(50, 93, 44, 47, 1'b0);
    clear_slots();
    set_slot(0, 90, 93, 0, 1);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_crashed", int'(bus.crashed), 0);
    chk("abort_hit_index", int'(bus.hit_index), 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen |= int'(bus.done);
    end
    chk("abort_no_done", seen, 0);

    set_trex(0, 93, 44, 47, 1'b0);
    clear_slots();
    set_slot(0, -20, 105, 0, 2);
    run(1'b0, d);
    chk("negx_done_cycle", d, 7);
    chk("negx_crashed", int'(bus.crashed), 1);

    for (int it = 0; it < 60; it++) begin
      rand_inputs();
      run(1'b1, d);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
